// File: rtl/work_arb_pkg.sv
// Shared types and helpers for the work_arbiter block: FSM state encoding,
// default result width, requester-index width helper and error payload bit.
package work_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam int DATA_W_DEF = 32;

    // Replicated across the result width when a job ends without a valid result.
    localparam logic ERR_DATA_BIT = 1'b0;

    // Width of a requester index; at least one bit even for tiny configurations.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/work_arbiter_rr_picker.sv
// Combinational round-robin selector for work_arbiter. The search begins at
// ptr+1 and wraps, so the requester served last has the lowest priority.
module rr_picker
    import work_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // Scan from farthest to nearest so the nearest requester after ptr overwrites last.
    always_comb begin
        any = 1'b0;
        idx = {ID_W{1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                any = 1'b1;
                idx = ID_W'((int'(ptr) + k) % N_REQ);
            end else begin
                any = any;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/work_arbiter.sv
// work_arbiter: shares one start/finish worker among N_REQ requesters.
// A round-robin winner is launched with a one-cycle start/grant pulse, the
// worker result is captured on wk_done and returned on a valid/ready port
// tagged with the requester index. All outputs are registered.
// Optional build macro WORK_TIMEOUT_EN bounds the WAIT state to TIMEOUT
// cycles and reports an error response when the worker never finishes.
module work_arbiter
    import work_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        wk_start,
    output logic                        wk_almfull,
    input  logic                        wk_done,
    input  logic                        wk_valid,
    input  logic [DATA_W-1:0]           wk_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_width(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_e          state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     cur_id_r;
    logic [N_REQ-1:0]    grant_r;
    logic                busy_r;
    logic                wk_start_r;
    logic                wk_almfull_r;
    logic                rsp_valid_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_err_r;

    logic                pick_any_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                tmo_hit_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

`ifdef WORK_TIMEOUT_EN
    localparam int TMO_W = 16;
    logic [TMO_W-1:0] tmo_cnt_r;

    // Count cycles spent in WAIT; cleared in LAUNCH so it starts at zero on WAIT entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_LAUNCH) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // The last permitted WAIT cycle is the one where the count equals TIMEOUT-1.
    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Main controller: state, priority pointer and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= ID_W'(N_REQ - 1);
            cur_id_r     <= {ID_W{1'b0}};
            grant_r      <= {N_REQ{1'b0}};
            busy_r       <= 1'b0;
            wk_start_r   <= 1'b0;
            wk_almfull_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp_err_r    <= 1'b0;
        end else begin
            // Back-pressure mirrors a stalled response one cycle late.
            wk_almfull_r <= rsp_valid_r && !rsp_ready;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        cur_id_r   <= pick_idx_s;
                        grant_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        wk_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_LAUNCH;
                    end else begin
                        grant_r    <= {N_REQ{1'b0}};
                        wk_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    grant_r    <= {N_REQ{1'b0}};
                    wk_start_r <= 1'b0;
                    busy_r     <= 1'b1;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finishing worker takes precedence over a coincident timeout.
                    if (wk_done) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= cur_id_r;
                        rsp_data_r  <= wk_valid ? wk_data : {DATA_W{ERR_DATA_BIT}};
                        rsp_err_r   <= !wk_valid;
                        state_r     <= ST_RESP;
                    end else if (tmo_hit_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= cur_id_r;
                        rsp_data_r  <= {DATA_W{ERR_DATA_BIT}};
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r     <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    // Payload holds until accepted; only acceptance moves the pointer.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ptr_r       <= cur_id_r;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    grant_r     <= {N_REQ{1'b0}};
                    wk_start_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign busy       = busy_r;
    assign wk_start   = wk_start_r;
    assign wk_almfull = wk_almfull_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;

endmodule
